exibe_sequencia: RTL and testbench

//  Presenter side of the memory game: plays the stored sequence back to the player on the LEDs.
//  On a start pulse it walks ROM addresses 0..limite and shows each stored 4-bit value on the LEDs.

---
 rtl/exibe_sequencia_pkg.sv | 24 ++
 rtl/exibe_sequencia_temporizador.sv | 29 ++
 rtl/exibe_sequencia.sv | 118 +++++++++++
 tb/tb_exibe_sequencia.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exibe_sequencia_pkg.sv
// Shared definitions for the sequence presenter: state encoding (also decoded by the
// top-level FSM for the hex display) and the ROM geometry.
package exibe_sequencia_pkg;

    localparam int ENDERECO_W = 4;
    localparam int DADO_W     = 4;

    localparam logic [3:0] COD_INICIAL = 4'd0;
    localparam logic [3:0] COD_CARREGA = 4'd1;
    localparam logic [3:0] COD_ACENDE  = 4'd2;
    localparam logic [3:0] COD_APAGA   = 4'd3;
    localparam logic [3:0] COD_PROXIMO = 4'd4;
    localparam logic [3:0] COD_FIM     = 4'd5;

    typedef enum logic [3:0] {
        INICIAL = COD_INICIAL,
        CARREGA = COD_CARREGA,
        ACENDE  = COD_ACENDE,
        APAGA   = COD_APAGA,
        PROXIMO = COD_PROXIMO,
        FIM     = COD_FIM
    } estado_t;

endpackage

// File: rtl/exibe_sequencia_temporizador.sv
// N-bit up-counter with synchronous clear and enable; times the lit and dark phases.
module exibe_sequencia_temporizador #(
    parameter int N = 12
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [N-1:0] o_contagem
);

    logic [N-1:0] r_contagem;

    // Counter register: reset and clear dominate, otherwise count while enabled.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_contagem <= {N{1'b0}};
        end else if (i_clr) begin
            r_contagem <= {N{1'b0}};
        end else if (i_en) begin
            r_contagem <= r_contagem + {{(N-1){1'b0}}, 1'b1};
        end else begin
            r_contagem <= r_contagem;
        end
    end

    assign o_contagem = r_contagem;

endmodule

// File: rtl/exibe_sequencia.sv
// Memory-game presenter: walks ROM addresses 0..limite and shows each value on the LEDs
// for T_ON cycles followed by T_OFF dark cycles, then pulses pronto.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int T_ON  = 1000,
    parameter int T_OFF = 500,
    parameter int N     = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [ENDERECO_W-1:0] limite,
    input  logic [DADO_W-1:0]     dado,
    output logic [ENDERECO_W-1:0] endereco,
    output logic [DADO_W-1:0]     leds,
    output logic                  exibindo,
    output logic                  pronto,
    output logic [3:0]            db_estado
);

    localparam logic [N-1:0] ON_ULTIMO  = N'(T_ON - 1);
    localparam logic [N-1:0] OFF_ULTIMO = N'(T_OFF - 1);

    estado_t               r_estado;
    estado_t               w_proximo;
    logic [ENDERECO_W-1:0] r_endereco;
    logic [ENDERECO_W-1:0] r_lim;
    logic [DADO_W-1:0]     r_leds;
    logic                  r_pronto;
    logic                  r_exibindo;
    logic [N-1:0]          w_timer;
    logic                  w_timer_clr;
    logic                  w_timer_en;

    exibe_sequencia_temporizador #(
        .N (N)
    ) u_temporizador (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_clr      (w_timer_clr),
        .i_en       (w_timer_en),
        .o_contagem (w_timer)
    );

    // Next-state and timer control; the timer is held at zero outside the timed states.
    always_comb begin
        w_proximo   = r_estado;
        w_timer_clr = 1'b1;
        w_timer_en  = 1'b0;
        case (r_estado)
            INICIAL: begin
                if (iniciar) w_proximo = CARREGA;
                else         w_proximo = INICIAL;
            end
            CARREGA: w_proximo = ACENDE;
            ACENDE: begin
                if (w_timer == ON_ULTIMO) begin
                    w_proximo = APAGA;
                end else begin
                    w_proximo   = ACENDE;
                    w_timer_clr = 1'b0;
                    w_timer_en  = 1'b1;
                end
            end
            APAGA: begin
                if (w_timer == OFF_ULTIMO) begin
                    w_proximo = PROXIMO;
                end else begin
                    w_proximo   = APAGA;
                    w_timer_clr = 1'b0;
                    w_timer_en  = 1'b1;
                end
            end
            PROXIMO: begin
                if (r_endereco == r_lim) w_proximo = FIM;
                else                     w_proximo = CARREGA;
            end
            FIM:     w_proximo = INICIAL;
            default: w_proximo = INICIAL;
        endcase
    end

    // State, address, limit and registered outputs. The ROM answers one cycle after the
    // address, so the LEDs load while in ACENDE rather than on the entering edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado   <= INICIAL;
            r_endereco <= {ENDERECO_W{1'b0}};
            r_lim      <= {ENDERECO_W{1'b0}};
            r_leds     <= {DADO_W{1'b0}};
            r_pronto   <= 1'b0;
            r_exibindo <= 1'b0;
        end else begin
            r_estado <= w_proximo;
            if (r_estado == INICIAL && iniciar) begin
                r_lim      <= limite;
                r_endereco <= {ENDERECO_W{1'b0}};
            end else if (r_estado == PROXIMO && r_endereco != r_lim) begin
                r_lim      <= r_lim;
                r_endereco <= r_endereco + {{(ENDERECO_W-1){1'b0}}, 1'b1};
            end else begin
                r_lim      <= r_lim;
                r_endereco <= r_endereco;
            end
            r_leds     <= (r_estado == ACENDE) ? dado : {DADO_W{1'b0}};
            r_pronto   <= (r_estado == FIM);
            r_exibindo <= (w_proximo != INICIAL);
        end
    end

    assign endereco  = r_endereco;
    assign leds      = r_leds;
    assign pronto    = r_pronto;
    assign exibindo  = r_exibindo;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with T_ON=4, T_OFF=2 and a behavioural sync ROM
// holding data[i] = i ^ 4'hA (address 10 therefore holds 0).
module tb_exibe_sequencia;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int PER   = T_ON + T_OFF + 2;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       exibindo;
    logic       pronto;
    logic [3:0] db_estado;

    int n_vet;
    int n_err;

    exibe_sequencia #(
        .T_ON  (T_ON),
        .T_OFF (T_OFF),
        .N     (12)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) dado <= endereco ^ 4'hA;

    function automatic logic [3:0] rom_val(input int a);
        logic [3:0] v;
        v = a[3:0];
        return v ^ 4'hA;
    endfunction

    // Caller sits at a falling edge; returns at the falling edge after the sampling edge.
    task automatic pulso_iniciar(input logic [3:0] lim);
        limite  = lim;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    // modo 0: plain run; 1: iniciar re-pulsed and limite zeroed mid-run; 2: iniciar during FIM
    task automatic verifica_execucao(input string nome, input int lim, input int modo);
        int total, e, fase;
        logic [3:0] exp_leds, exp_end, exp_est;
        logic exp_pronto, exp_exib;
        total = PER * (lim + 1);
        for (int t = 0; t <= total + 3; t++) begin
            e    = t / PER;
            fase = t % PER;
            exp_leds   = (t < total && fase >= 2 && fase <= T_ON + 1) ? rom_val(e) : 4'h0;
            exp_end    = (e > lim) ? 4'(lim) : 4'(e);
            exp_pronto = (t == total + 1);
            exp_exib   = (t <= total);
            if (t > total)                 exp_est = 4'd0;
            else if (t == total)           exp_est = 4'd5;
            else if (fase == 0)            exp_est = 4'd1;
            else if (fase <= T_ON)         exp_est = 4'd2;
            else if (fase <= T_ON + T_OFF) exp_est = 4'd3;
            else                           exp_est = 4'd4;
            n_vet += 5;
            if (leds !== exp_leds) begin
                n_err++;
                $display("FAIL %s leds t=%0d: got %h expected %h", nome, t, leds, exp_leds);
            end
            if (endereco !== exp_end) begin
                n_err++;
                $display("FAIL %s endereco t=%0d: got %h expected %h", nome, t, endereco, exp_end);
            end
            if (pronto !== exp_pronto) begin
                n_err++;
                $display("FAIL %s pronto t=%0d: got %b expected %b", nome, t, pronto, exp_pronto);
            end
            if (exibindo !== exp_exib) begin
                n_err++;
                $display("FAIL %s exibindo t=%0d: got %b expected %b", nome, t, exibindo, exp_exib);
            end
            if (db_estado !== exp_est) begin
                n_err++;
                $display("FAIL %s db_estado t=%0d: got %0d expected %0d", nome, t, db_estado, exp_est);
            end
            if (modo == 1 && t == 2)          begin iniciar = 1'b1; limite = 4'd0; end
            if (modo == 1 && t == 3)          iniciar = 1'b0;
            if (modo == 1 && t == PER + 3)    iniciar = 1'b1;
            if (modo == 1 && t == PER + 4)    iniciar = 1'b0;
            if (modo == 2 && t == total)      iniciar = 1'b1;
            if (modo == 2 && t == total + 1)  iniciar = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        iniciar = 1'b1;
        limite  = 4'd7;
        @(negedge clock);
        @(negedge clock);
        n_vet += 5;
        if (leds !== 4'h0)      begin n_err++; $display("FAIL reset leds: got %h expected 0", leds); end
        if (endereco !== 4'h0)  begin n_err++; $display("FAIL reset endereco: got %h expected 0", endereco); end
        if (pronto !== 1'b0)    begin n_err++; $display("FAIL reset pronto: got %b expected 0", pronto); end
        if (exibindo !== 1'b0)  begin n_err++; $display("FAIL reset exibindo: got %b expected 0", exibindo); end
        if (db_estado !== 4'd0) begin n_err++; $display("FAIL reset db_estado: got %0d expected 0", db_estado); end
        iniciar = 1'b0;
        reset   = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_vet += 1;
        if (exibindo !== 1'b0) begin n_err++; $display("FAIL idle exibindo: got %b expected 0", exibindo); end
    endtask

    task automatic test_single();
        pulso_iniciar(4'd0);
        verifica_execucao("single", 0, 0);
    endtask

    task automatic test_four();
        pulso_iniciar(4'd3);
        verifica_execucao("four", 3, 0);
    endtask

    task automatic test_full();
        pulso_iniciar(4'd15);
        verifica_execucao("full", 15, 0);
    endtask

    task automatic test_ignored_inputs();
        pulso_iniciar(4'd5);
        verifica_execucao("ignored", 5, 1);
    endtask

    task automatic test_abort();
        pulso_iniciar(4'd5);
        // advance to the first APAGA cycle of element 2
        for (int t = 0; t < 2 * PER + T_ON + 1; t++) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        n_vet += 4;
        if (leds !== 4'h0)     begin n_err++; $display("FAIL abort leds: got %h expected 0", leds); end
        if (endereco !== 4'h0) begin n_err++; $display("FAIL abort endereco: got %h expected 0", endereco); end
        if (exibindo !== 1'b0) begin n_err++; $display("FAIL abort exibindo: got %b expected 0", exibindo); end
        if (pronto !== 1'b0)   begin n_err++; $display("FAIL abort pronto: got %b expected 0", pronto); end
        for (int t = 0; t < 3 * PER; t++) begin
            n_vet += 1;
            if (pronto !== 1'b0 || exibindo !== 1'b0) begin
                n_err++;
                $display("FAIL abort idle t=%0d: got pronto=%b exibindo=%b expected 0/0", t, pronto, exibindo);
            end
            @(negedge clock);
        end
        pulso_iniciar(4'd1);
        verifica_execucao("restart", 1, 0);
    endtask

    task automatic test_zero_slot();
        pulso_iniciar(4'd10);
        verifica_execucao("zero_slot", 10, 2);
    endtask

    initial begin
        n_vet = 0;
        n_err = 0;
        reset   = 1'b0;
        iniciar = 1'b0;
        limite  = 4'd0;
        @(negedge clock);
        test_reset();
        test_single();
        test_four();
        test_full();
        test_ignored_inputs();
        test_abort();
        test_zero_slot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vet, n_err);
        $finish;
    end

endmodule
